// File: rtl/prog_launcher.sv
// Front-end sequencer: clears and preloads data memory with the core held in START,
// runs the core until DONE or timeout, then streams a window of result bytes.
module prog_launcher #(
    parameter int          AW       = 8,
    parameter int          DW       = 8,
    parameter int          RD_BASE  = 5,
    parameter int          RD_COUNT = 4,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          GO,
    input  logic          CLR_EN,
    input  logic          LD_VALID,
    output logic          LD_READY,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [DW-1:0] LD_DATA,
    input  logic          LD_LAST,
    output logic          DM_WE,
    output logic [AW-1:0] DM_ADDR,
    output logic [DW-1:0] DM_WDATA,
    input  logic [DW-1:0] DM_RDATA,
    output logic          START,
    input  logic          DONE,
    output logic          RES_VALID,
    output logic [AW-1:0] RES_ADDR,
    output logic [DW-1:0] RES_DATA,
    output logic          BUSY,
    output logic          TIMED_OUT
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_LAUNCH, S_RUN, S_READ, S_FIN
    } state_t;

    localparam logic [AW:0]   RD_N     = (AW+1)'(RD_COUNT);
    localparam logic [AW-1:0] RD_FIRST = AW'(RD_BASE);
    localparam logic [31:0]   RUN_LAST = 32'(TIMEOUT - 1);

    state_t        state, next_state;
    logic [AW-1:0] clr_addr;
    logic [31:0]   run_cnt;
    logic [AW:0]   rd_idx;
    logic [AW-1:0] rd_addr;
    logic          rd_issue;
    logic          run_expired;
    logic          res_valid;
    logic [AW-1:0] res_addr;
    logic          timed_out;

    assign rd_issue    = (state == S_READ) && (rd_idx < RD_N);
    assign rd_addr     = RD_FIRST + rd_idx[AW-1:0];
    assign run_expired = (TIMEOUT != 0) && (run_cnt == RUN_LAST);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (GO) next_state = CLR_EN ? S_CLEAR : S_LOAD;
            S_CLEAR:  if (clr_addr == '1) next_state = S_LOAD;
            S_LOAD:   if (LD_VALID && LD_LAST) next_state = S_LAUNCH;
            S_LAUNCH: next_state = S_RUN;
            S_RUN: begin
                // DONE in the last allowed cycle still wins over the timeout
                if (DONE)             next_state = S_READ;
                else if (run_expired) next_state = S_FIN;
            end
            S_READ:   if (rd_idx == RD_N) next_state = S_FIN;
            S_FIN:    if (!GO) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        START    = (state != S_RUN);
        BUSY     = (state != S_IDLE) && (state != S_FIN);
        LD_READY = 1'b0;
        DM_WE    = 1'b0;
        DM_ADDR  = '0;
        DM_WDATA = '0;
        case (state)
            S_CLEAR: begin
                DM_WE   = 1'b1;
                DM_ADDR = clr_addr;
            end
            S_LOAD: begin
                // Write lands in the handshake cycle itself, no registered WE
                LD_READY = 1'b1;
                DM_WE    = LD_VALID;
                DM_ADDR  = LD_ADDR;
                DM_WDATA = LD_DATA;
            end
            S_READ:  if (rd_issue) DM_ADDR = rd_addr;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clr_addr  <= '0;
            run_cnt   <= '0;
            rd_idx    <= '0;
            res_valid <= 1'b0;
            res_addr  <= '0;
            timed_out <= 1'b0;
        end else begin
            clr_addr  <= (state == S_CLEAR) ? clr_addr + 1'b1 : '0;
            run_cnt   <= (state == S_RUN) ? run_cnt + 32'd1 : '0;
            rd_idx    <= (state == S_READ) ? rd_idx + 1'b1 : '0;
            res_valid <= rd_issue;
            if (rd_issue) res_addr <= rd_addr;
            if (state == S_IDLE && GO)
                timed_out <= 1'b0;
            else if (state == S_RUN && !DONE && run_expired)
                timed_out <= 1'b1;
        end
    end

    // Read data arrives one cycle after the address, alongside the strobe
    assign RES_VALID = res_valid;
    assign RES_ADDR  = res_addr;
    assign RES_DATA  = res_valid ? DM_RDATA : '0;
    assign TIMED_OUT = timed_out;

endmodule

// File: tb/tb_prog_launcher.sv
// Scoreboard bench for prog_launcher: memory and core models, spec-level reference
// memory image, and a monitor that checks every streamed result byte.
module tb_prog_launcher;
    localparam int AW = 8, DW = 8, RD_BASE = 254, RD_COUNT = 4, TIMEOUT = 40;
    localparam int DEPTH = 256;

    logic CLK = 1'b0, RESET = 1'b1;
    logic GO = 1'b0, CLR_EN = 1'b0, LD_VALID = 1'b0, LD_LAST = 1'b0, DONE = 1'b0;
    logic [AW-1:0] LD_ADDR = '0;
    logic [DW-1:0] LD_DATA = '0;
    logic LD_READY, DM_WE, START, RES_VALID, BUSY, TIMED_OUT;
    logic [AW-1:0] DM_ADDR, RES_ADDR;
    logic [DW-1:0] DM_WDATA, DM_RDATA, RES_DATA;

    logic          core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_data = '0;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    typedef struct { int addr; int data; } res_t;
    res_t exp_q[$];
    int   ld_a[$], ld_d[$], ld_gap[$], cw_a[$], cw_d[$];
    int   n_cmp = 0, n_err = 0, n_res = 0;

    prog_launcher #(.AW(AW), .DW(DW), .RD_BASE(RD_BASE), .RD_COUNT(RD_COUNT),
                    .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .GO(GO), .CLR_EN(CLR_EN),
        .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_ADDR(LD_ADDR),
        .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR),
        .DM_WDATA(DM_WDATA), .DM_RDATA(DM_RDATA), .START(START), .DONE(DONE),
        .RES_VALID(RES_VALID), .RES_ADDR(RES_ADDR), .RES_DATA(RES_DATA),
        .BUSY(BUSY), .TIMED_OUT(TIMED_OUT)
    );

    always #5 CLK = ~CLK;

    // Data memory: launcher port has priority, core port used while the core runs
    always @(posedge CLK) begin
        if (DM_WE)        mem[DM_ADDR] <= DM_WDATA;
        else if (core_we) mem[core_addr] <= core_data;
        DM_RDATA <= mem[DM_ADDR];
    end

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    always @(negedge CLK) begin
        res_t e;
        if (!RESET && RES_VALID) begin
            n_res++;
            if (exp_q.size() == 0) begin
                check("res_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("res_addr", int'(RES_ADDR), e.addr);
                check("res_data", int'(RES_DATA), e.data);
            end
        end
    end

    function automatic int rand_addr();
        if ($urandom_range(0, 1) == 1)
            return (RD_BASE + int'($urandom_range(0, RD_COUNT - 1))) % DEPTH;
        return int'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic plan_reset();
        ld_a.delete(); ld_d.delete(); ld_gap.delete(); cw_a.delete(); cw_d.delete();
    endtask

    task automatic add_ld(input int a, input int d, input int gap);
        ld_a.push_back(a); ld_d.push_back(d); ld_gap.push_back(gap);
    endtask

    task automatic add_cw(input int a, input int d);
        cw_a.push_back(a); cw_d.push_back(d);
    endtask

    task automatic pulse_reset(input string tag);
        #2 RESET = 1'b1;
        #1;
        check({tag, "_ctl"}, int'({START, BUSY, DM_WE, LD_READY, RES_VALID, TIMED_OUT}), 32);
        check({tag, "_bus"}, int'({DM_ADDR, DM_WDATA, RES_ADDR, RES_DATA}), 0);
        @(negedge CLK);
        RESET = 1'b0; GO = 1'b0; LD_VALID = 1'b0; LD_LAST = 1'b0; DONE = 1'b0; core_we = 1'b0;
        #1;
    endtask

    // abort: 0 = full sequence, 1 = reset in CLEAR, 2 = reset in RUN
    task automatic run_seq(input bit clr, input int done_at, input bit hold_go, input int abort);
        int good, bad, n0, cyc, a;
        res_t e;
        check("idle_ctl", int'({START, BUSY, LD_READY, DM_WE}), 8);
        GO = 1'b1; CLR_EN = clr;
        @(negedge CLK); #1;
        if (!hold_go) GO = 1'b0;
        check("armed_busy_to", int'({BUSY, TIMED_OUT}), 2);
        if (clr) begin
            good = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (abort == 1 && i == 100) begin
                    pulse_reset("rst_mid_clear");
                    return;
                end
                if (DM_WE && int'(DM_ADDR) == i && DM_WDATA == '0 && START && !LD_READY) good++;
                ref_mem[i] = '0;
                @(negedge CLK); #1;
            end
            check("clear_writes", good, DEPTH);
        end
        check("load_ready", int'(LD_READY), 1);
        good = 0; bad = 0;
        for (int k = 0; k < ld_a.size(); k++) begin
            for (int g = 0; g < ld_gap[k]; g++) begin
                LD_VALID = 1'b0; LD_ADDR = AW'($urandom); LD_DATA = DW'($urandom);
                #1;
                if (DM_WE || !LD_READY) bad++;
                @(negedge CLK); #1;
            end
            LD_VALID = 1'b1; LD_ADDR = AW'(ld_a[k]); LD_DATA = DW'(ld_d[k]);
            LD_LAST = (k == ld_a.size() - 1);
            #1;
            if (DM_WE && DM_ADDR == AW'(ld_a[k]) && DM_WDATA == DW'(ld_d[k]) && START) good++;
            ref_mem[ld_a[k]] = DW'(ld_d[k]);
            @(negedge CLK); #1;
        end
        LD_VALID = 1'b0; LD_LAST = 1'b0;
        #1;
        check("load_writes", good, ld_a.size());
        check("load_gap_spurious", bad, 0);
        check("launch_ctl", int'({START, LD_READY, DM_WE}), 4);
        @(negedge CLK); #1;
        check("run_start_low", int'(START), 0);

        n0 = n_res; bad = 0; cyc = -1;
        for (int c = 0; c < TIMEOUT + 8; c++) begin
            if (abort == 2 && c == 5) begin
                pulse_reset("rst_mid_run");
                return;
            end
            core_we = (c < cw_a.size());
            if (c < cw_a.size()) begin
                core_addr = AW'(cw_a[c]); core_data = DW'(cw_d[c]);
                ref_mem[cw_a[c]] = DW'(cw_d[c]);
            end
            DONE = (c == done_at);
            LD_VALID = 1'($urandom_range(0, 1));
            #1;
            if (TIMED_OUT) begin
                cyc = c;
                break;
            end
            if (START || DM_WE || LD_READY || RES_VALID) bad++;
            if (DONE) begin
                for (int i = 0; i < RD_COUNT; i++) begin
                    a = (RD_BASE + i) % DEPTH;
                    e.addr = a; e.data = int'(ref_mem[a]);
                    exp_q.push_back(e);
                end
                cyc = c;
                break;
            end
            @(negedge CLK); #1;
        end
        core_we = 1'b0; LD_VALID = 1'b0;
        check("run_quiet", bad, 0);
        if (done_at < 0) begin
            check("timeout_cycle", cyc, TIMEOUT);
            check("fin_ctl_timeout", int'({START, BUSY, TIMED_OUT}), 5);
            repeat (3) @(negedge CLK);
            #1;
            check("timeout_no_results", n_res - n0, 0);
        end else begin
            @(negedge CLK);
            DONE = 1'b0;
            #1;
            good = 0; bad = 0;
            while (BUSY && good < 20) begin
                if (!START) bad++;
                good++;
                @(negedge CLK); #1;
            end
            check("read_cycles", good, RD_COUNT + 1);
            check("read_start_high", bad, 0);
            check("fin_ctl_done", int'({START, BUSY, TIMED_OUT}), 4);
            check("result_count", n_res - n0, RD_COUNT);
            check("scoreboard_left", exp_q.size(), 0);
            exp_q.delete();
        end
        if (hold_go) begin
            bad = 0;
            repeat (3) begin
                @(negedge CLK); #1;
                if (BUSY || LD_READY || DM_WE || !START) bad++;
            end
            check("fin_no_retrigger", bad, 0);
        end
        GO = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
    endtask

    initial begin
        #1;
        check("reset_ctl", int'({START, BUSY, DM_WE, LD_READY, RES_VALID, TIMED_OUT}), 32);
        check("reset_bus", int'({DM_ADDR, DM_WDATA, RES_ADDR, RES_DATA}), 0);
        for (int i = 0; i < DEPTH; i++) begin
            core_we = 1'b1; core_addr = AW'(i); core_data = DW'($urandom);
            ref_mem[i] = core_data;
            @(negedge CLK);
        end
        core_we = 1'b0;
        RESET = 1'b0;
        #1;

        plan_reset();
        add_ld(0, 85, 0); add_ld(1, 5, 0); add_ld(60, 240, 0); add_ld(68, 255, 0);
        add_cw(254, 1); add_cw(255, 2); add_cw(0, 3); add_cw(1, 4);
        run_seq(1'b1, 20, 1'b0, 0);

        plan_reset();
        add_ld(254, 9, 1); add_ld(7, 77, 1); add_ld(0, 200, 1);
        run_seq(1'b0, -1, 1'b0, 0);
        check("timed_out_sticky", int'(TIMED_OUT), 1);

        plan_reset();
        add_ld(255, 17, 3); add_ld(10, 51, 3); add_ld(255, 34, 3);
        run_seq(1'b0, 10, 1'b0, 0);

        plan_reset();
        add_ld(0, 90, 0); add_cw(1, 119);
        run_seq(1'b0, TIMEOUT - 1, 1'b1, 0);

        plan_reset();
        add_ld(3, 9, 0);
        run_seq(1'b0, 30, 1'b0, 2);

        plan_reset();
        add_ld(3, 9, 0);
        run_seq(1'b1, 30, 1'b0, 1);

        for (int s = 0; s < 8; s++) begin
            int n, d;
            bit clr;
            plan_reset();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) add_ld(rand_addr(), $urandom_range(0, 255), $urandom_range(0, 3));
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) add_cw(rand_addr(), $urandom_range(0, 255));
            d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(n, TIMEOUT - 1));
            clr = (s == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            run_seq(clr, d, 1'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached after %0d comparisons", n_cmp);
        $fatal(1, "simulation time limit");
    end

endmodule
